// File: rtl/intr_gen_pkg.sv
// rtl/intr_gen_pkg.sv - shared constants and helpers for the interrupt coalescing generator
package intr_gen_pkg;

  // One-hot channel states
  localparam int ST_W = 4;
  localparam logic [ST_W-1:0] ST_IDLE    = 4'b0001;
  localparam logic [ST_W-1:0] ST_PEND    = 4'b0010;
  localparam logic [ST_W-1:0] ST_REQ     = 4'b0100;
  localparam logic [ST_W-1:0] ST_WAIT_SW = 4'b1000;

  localparam int EVT_CNT_W = 8;
  localparam int TMR_W     = 16;
  localparam int HOLDOFF_W = 16;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/intr_rr_arbiter.sv
// rtl/intr_rr_arbiter.sv - round-robin picker; search starts after the last acked channel
module intr_rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              ack_i,
  input  logic [CH_W-1:0]   ack_idx_i,
  output logic [CH_W-1:0]   gnt_idx_o,
  output logic              gnt_valid_o
);

  logic [CH_W-1:0] last_q, last_d;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (req_i[(int'(last_q) + k) % NUM_CH]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = CH_W'((int'(last_q) + k) % NUM_CH);
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (ack_i) last_d = ack_idx_i;
  end

  // Reset to the highest index so channel 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= CH_W'(NUM_CH - 1);
    else       last_q <= last_d;
  end

endmodule

// File: rtl/intr_coalesce_gen.sv
// rtl/intr_coalesce_gen.sv - per-channel event coalescing FSMs feeding one req/ack interrupt port; INTR_COALESCE_HOLDOFF_EN adds a global gap timer
module intr_coalesce_gen
  import intr_gen_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int PTR_W          = 64,
  parameter int COAL_CNT       = 8,
  parameter int COAL_TIMEOUT   = 1024,
  parameter int HOLDOFF_CYCLES = 256,
  localparam int CH_W          = ch_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*PTR_W-1:0] hw_pointer,
  input  logic [NUM_CH*PTR_W-1:0] sw_pointer,
  input  logic [NUM_CH-1:0]       data_ready,
  input  logic [NUM_CH-1:0]       intr_enable,
  output logic                    intr_req,
  output logic [CH_W-1:0]         intr_vector,
  input  logic                    intr_ack,
  output logic [NUM_CH-1:0]       intr_pending
);

  localparam logic [EVT_CNT_W-1:0] CNT_THR  = EVT_CNT_W'(COAL_CNT);
  localparam logic [TMR_W-1:0]     TMO_LAST = TMR_W'(COAL_TIMEOUT - 1);

  logic                intr_req_q, intr_req_d;
  logic [CH_W-1:0]     intr_vector_q, intr_vector_d;
  logic [NUM_CH-1:0]   elig;
  logic [CH_W-1:0]     gnt_idx;
  logic                gnt_valid;
  logic                ack_fire;
  logic                hold_ok;

  assign ack_fire = intr_req_q & intr_ack;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [ST_W-1:0]      state_q, state_d;
    logic [EVT_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic                 missed_q, missed_d;
    logic                 acked, ptr_eq, elig_c, pend_c;

    assign acked   = ack_fire && (intr_vector_q == CH_W'(c));
    assign ptr_eq  = hw_pointer[c*PTR_W +: PTR_W] == sw_pointer[c*PTR_W +: PTR_W];
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q  <= ST_IDLE;
        cnt_q    <= '0;
        tmr_q    <= '0;
        missed_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        tmr_q    <= tmr_d;
        missed_q <= missed_d;
      end
    end

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tmr_d    = tmr_q;
      missed_d = missed_q;
      case (state_q)
        ST_IDLE: begin
          if (data_ready[c]) begin
            cnt_d   = EVT_CNT_W'(1);
            tmr_d   = '0;
            state_d = (COAL_CNT == 1) ? ST_REQ : ST_PEND;
          end
        end
        ST_PEND: begin
          if (data_ready[c]) cnt_d = cnt_inc;
          tmr_d = tmr_q + 1'b1;
          if (cnt_d >= CNT_THR || tmr_q == TMO_LAST) state_d = ST_REQ;
        end
        ST_REQ: begin
          // Events while waiting for the grant are absorbed.
          if (acked) begin
            state_d  = ST_WAIT_SW;
            cnt_d    = '0;
            tmr_d    = '0;
            missed_d = 1'b0;
          end
        end
        ST_WAIT_SW: begin
          if (ptr_eq) begin
            missed_d = 1'b0;
            if (missed_q || data_ready[c]) begin
              state_d = ST_PEND;
              cnt_d   = EVT_CNT_W'(1);
              tmr_d   = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (data_ready[c]) begin
            missed_d = 1'b1;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          tmr_d    = '0;
          missed_d = 1'b0;
        end
      endcase
    end

    always_comb begin
      elig_c = (state_q == ST_REQ) && intr_enable[c];
      pend_c = (state_q == ST_PEND) || (state_q == ST_REQ);
    end

    assign elig[c]         = elig_c;
    assign intr_pending[c] = pend_c;
  end

  intr_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_i       (elig),
    .ack_i       (ack_fire),
    .ack_idx_i   (intr_vector_q),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

`ifdef INTR_COALESCE_HOLDOFF_EN
  logic [HOLDOFF_W-1:0] holdoff_q, holdoff_d;

  always_comb begin
    holdoff_d = holdoff_q;
    if (ack_fire)                holdoff_d = HOLDOFF_W'(HOLDOFF_CYCLES);
    else if (holdoff_q != '0)    holdoff_d = holdoff_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) holdoff_q <= '0;
    else       holdoff_q <= holdoff_d;
  end

  assign hold_ok = (holdoff_q == '0);
`else
  assign hold_ok = 1'b1;
`endif

  // Ack takes priority, so a new grant can only load on the following edge.
  always_comb begin
    intr_req_d    = intr_req_q;
    intr_vector_d = intr_vector_q;
    if (ack_fire) begin
      intr_req_d = 1'b0;
    end else if (!intr_req_q && gnt_valid && hold_ok) begin
      intr_req_d    = 1'b1;
      intr_vector_d = gnt_idx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      intr_req_q    <= 1'b0;
      intr_vector_q <= '0;
    end else begin
      intr_req_q    <= intr_req_d;
      intr_vector_q <= intr_vector_d;
    end
  end

  assign intr_req    = intr_req_q;
  assign intr_vector = intr_vector_q;

endmodule

// File: tb/tb_intr_coalesce_gen.sv
// tb/tb_intr_coalesce_gen.sv - directed bench: dut_a uses COAL_CNT=1, dut_b uses COAL_CNT=8 with COAL_TIMEOUT=100
module tb_intr_coalesce_gen;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [127:0] a_hw, a_sw, b_hw, b_sw;
  logic [1:0]   a_dr, a_en, a_pend, b_dr, b_en, b_pend;
  logic         a_ack, a_req, b_ack, b_req;
  logic [0:0]   a_vec, b_vec;

  int total = 0;
  int bad   = 0;
  int n;
  int rises;

  intr_coalesce_gen #(
    .NUM_CH(2), .PTR_W(64), .COAL_CNT(1), .COAL_TIMEOUT(1024), .HOLDOFF_CYCLES(50)
  ) dut_a (
    .clk(clk), .reset(reset), .hw_pointer(a_hw), .sw_pointer(a_sw),
    .data_ready(a_dr), .intr_enable(a_en), .intr_req(a_req), .intr_vector(a_vec),
    .intr_ack(a_ack), .intr_pending(a_pend)
  );

  intr_coalesce_gen #(
    .NUM_CH(2), .PTR_W(64), .COAL_CNT(8), .COAL_TIMEOUT(100), .HOLDOFF_CYCLES(50)
  ) dut_b (
    .clk(clk), .reset(reset), .hw_pointer(b_hw), .sw_pointer(b_sw),
    .data_ready(b_dr), .intr_enable(b_en), .intr_req(b_req), .intr_vector(b_vec),
    .intr_ack(b_ack), .intr_pending(b_pend)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    a_hw = 128'd5; a_sw = '0; b_hw = '0; b_sw = '0;
    a_dr = '0; b_dr = '0; a_en = 2'b11; b_en = 2'b11; a_ack = 1'b0; b_ack = 1'b0;
    tick(); tick();
    chk("rst_a_req", a_req, 0);
    chk("rst_a_vec", a_vec, 0);
    chk("rst_a_pend", a_pend, 0);
    chk("rst_b_req", b_req, 0);
    chk("rst_b_pend", b_pend, 0);
    reset = 1'b0;
    tick();

    // Count threshold: 8 pulses on ch1, 3 cycles apart
    for (int k = 1; k <= 8; k++) begin
      b_dr = 2'b10;
      tick();
      b_dr = 2'b00;
      if (k < 8) begin
        tick(); tick();
        chk("b_no_early_req", b_req, 0);
      end
    end
    chk("b_thr_state", b_pend, 2'b10);
    chk("b_thr_req_lat1", b_req, 0);
    tick();
    chk("b_thr_req", b_req, 1);
    chk("b_thr_vec", b_vec, 1);
    b_ack = 1'b1; tick(); b_ack = 1'b0;
    chk("b_thr_ack", b_req, 0);
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (b_req) rises++;
    end
    chk("b_single_req", rises, 0);

    // Timeout: 3 pulses on ch0 at t0, t0+3, t0+6
    b_dr = 2'b01; tick(); b_dr = 2'b00;
    n = 0;
    while (b_req !== 1'b1 && n < 300) begin
      n++;
      b_dr = (n == 3 || n == 6) ? 2'b01 : 2'b00;
      tick();
    end
    b_dr = 2'b00;
    chk("b_tmo_lat", (n >= 100 && n <= 101), 1);
    chk("b_tmo_vec", b_vec, 0);
    b_ack = 1'b1; tick(); b_ack = 1'b0;
    chk("b_tmo_ack", b_req, 0);

    // COAL_CNT=1 latency on ch0 (hw0 != sw0 keeps it in WAIT_SW after ack)
    a_dr = 2'b01; tick(); a_dr = 2'b00;
    chk("a_cc1_state", a_pend, 2'b01);
    chk("a_cc1_lat0", a_req, 0);
    tick();
    chk("a_cc1_req", a_req, 1);
    chk("a_cc1_vec", a_vec, 0);
    tick(); tick();
    chk("a_req_held", a_req, 1);
    a_ack = 1'b1; tick(); a_ack = 1'b0;
    chk("a_ack_drop", a_req, 0);
    chk("a_ack_pend", a_pend, 0);

    // Missed event in WAIT_SW replays once software catches up
    tick();
    a_dr = 2'b01; tick(); a_dr = 2'b00;
    chk("a_wait_absorb", a_pend, 0);
    tick();
    chk("a_wait_hold", a_pend, 0);
    a_sw = 128'd5; tick();
    chk("a_missed_pend", a_pend, 2'b01);
    chk("a_missed_noreq", a_req, 0);
    tick();
    chk("a_missed_req_state", a_pend, 2'b01);
    tick();
    chk("a_second_req", a_req, 1);
    chk("a_second_vec", a_vec, 0);
    a_ack = 1'b1; tick(); a_ack = 1'b0;
    chk("a_second_ack", a_req, 0);
    tick();
    chk("a_idle_pend", a_pend, 0);
    a_dr = 2'b01; tick(); a_dr = 2'b00;
    chk("a_idle_to_req", a_pend, 2'b01);
    tick();
    chk("a_idle_req", a_req, 1);
    a_ack = 1'b1; tick(); a_ack = 1'b0;
    tick();

    // Round robin from a fresh reset
    reset = 1'b1; tick(); reset = 1'b0;
    a_dr = 2'b11; tick(); a_dr = 2'b00;
    chk("rr_both_pend", a_pend, 2'b11);
    tick();
    chk("rr_first_req", a_req, 1);
    chk("rr_first_vec", a_vec, 0);
    tick();
    a_ack = 1'b1; tick(); a_ack = 1'b0;
    chk("rr_first_ack", a_req, 0);
    chk("rr_first_pend", a_pend, 2'b10);
    tick();
    chk("rr_second_req", a_req, 1);
    chk("rr_second_vec", a_vec, 1);
    tick();
    a_ack = 1'b1; tick(); a_ack = 1'b0;
    chk("rr_second_ack", a_req, 0);
    chk("rr_second_pend", a_pend, 0);
    tick();
    a_dr = 2'b11; tick(); a_dr = 2'b00;
    chk("rr_again_pend", a_pend, 2'b11);
    tick();
    chk("rr_wrap_req", a_req, 1);
    chk("rr_wrap_vec", a_vec, 0);

    // Asynchronous reset while requesting
    reset = 1'b1;
    #2;
    chk("async_rst_req", a_req, 0);
    chk("async_rst_pend", a_pend, 0);
    chk("async_rst_vec", a_vec, 0);
    tick();
    reset = 1'b0;
    tick();

`ifdef INTR_COALESCE_HOLDOFF_EN
    a_dr = 2'b01; tick(); a_dr = 2'b00;
    tick();
    chk("ho_first_req", a_req, 1);
    a_ack = 1'b1; tick(); a_ack = 1'b0;
    a_dr = 2'b01; tick(); a_dr = 2'b00;
    n = 1;
    while (a_req !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("ho_second_req", a_req, 1);
    chk("ho_gap", (n >= 50 && n <= 52), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
